// File: rtl/forth_stack.sv
`default_nettype none
// ============================================================================
// Module   : forth_stack
// Purpose  : Forth data/return stack engine. The top two entries live in
//            registers (tos/nos); deeper entries spill to a synchronous-read
//            RAM of DEPTH-2 words. Stack words execute as single accepted
//            operations under a valid/ready handshake.
// Ports    : i_clk, i_rst_n (async, active-low)
//            i_op_valid / o_op_ready  - operation handshake
//            i_op[2:0], i_op_wdata    - opcode and PUSH/REPLACE operand
//            o_tos, o_nos             - registered top / next of stack
//            o_depth, o_empty, o_full - entry count and status
//            o_err_overflow, o_err_underflow, i_err_clear - sticky errors
// Revision : 1.0 - initial release
// ============================================================================
module forth_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_op_valid,
  output logic                   o_op_ready,
  input  logic [2:0]             i_op,
  input  logic [WIDTH-1:0]       i_op_wdata,
  output logic [WIDTH-1:0]       o_tos,
  output logic [WIDTH-1:0]       o_nos,
  output logic [$clog2(DEPTH):0] o_depth,
  output logic                   o_empty,
  output logic                   o_full,
  output logic                   o_err_overflow,
  output logic                   o_err_underflow,
  input  logic                   i_err_clear
);

  localparam int DW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH - 2);

  localparam logic [2:0] c_OP_NOP     = 3'd0;
  localparam logic [2:0] c_OP_PUSH    = 3'd1;
  localparam logic [2:0] c_OP_DROP    = 3'd2;
  localparam logic [2:0] c_OP_DUP     = 3'd3;
  localparam logic [2:0] c_OP_SWAP    = 3'd4;
  localparam logic [2:0] c_OP_OVER    = 3'd5;
  localparam logic [2:0] c_OP_REPLACE = 3'd6;
  localparam logic [2:0] c_OP_ROT     = 3'd7;

  localparam logic [DW-1:0] c_DEPTH_MAX = DW'(DEPTH);

  typedef enum logic [1:0] {
    ST_READY  = 2'd0,
    ST_REFILL = 2'd1,
    ST_ROT_RD = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [WIDTH-1:0]  r_tos;
  logic [WIDTH-1:0]  r_nos;
  logic [DW-1:0]     r_depth;
  logic              r_err_ovf;
  logic              r_err_unf;
  logic [WIDTH-1:0]  r_rdata;
  logic [WIDTH-1:0]  r_mem [0:DEPTH-3];

  logic              w_d_ge1;
  logic              w_d_ge2;
  logic              w_d_ge3;
  logic              w_is_full;
  logic [AW-1:0]     w_addr_m2;
  logic [AW-1:0]     w_addr_m3;
  logic              w_legal;
  logic              w_ovf_cause;
  logic              w_push;
  logic [WIDTH-1:0]  w_push_val;
  logic              w_accept;
  logic              w_do;
  logic              w_reject;
  logic              w_mem_we;
  logic [AW-1:0]     w_mem_waddr;
  logic              w_mem_re;

  assign w_d_ge1   = (r_depth != '0);
  assign w_d_ge2   = (r_depth >= DW'(2));
  assign w_d_ge3   = (r_depth >= DW'(3));
  assign w_is_full = (r_depth == c_DEPTH_MAX);

  // Entry i of the stack sits at RAM address i, so the entry just below nos
  // is d-3 and the slot nos spills into on a push is d-2.
  assign w_addr_m2 = AW'(r_depth - DW'(2));
  assign w_addr_m3 = AW'(r_depth - DW'(3));

  // Legality decode. A full stack is the only overflow cause; every other
  // rejection is an underflow.
  always_comb begin
    w_legal     = 1'b1;
    w_ovf_cause = 1'b0;
    w_push      = 1'b0;
    w_push_val  = i_op_wdata;
    case (i_op)
      c_OP_NOP: w_legal = 1'b1;
      c_OP_PUSH: begin
        w_push      = 1'b1;
        w_legal     = !w_is_full;
        w_ovf_cause = w_is_full;
      end
      c_OP_DROP: w_legal = w_d_ge1;
      c_OP_DUP: begin
        w_push      = 1'b1;
        w_push_val  = r_tos;
        w_legal     = w_d_ge1 && !w_is_full;
        w_ovf_cause = w_is_full;
      end
      c_OP_SWAP: w_legal = w_d_ge2;
      c_OP_OVER: begin
        w_push      = 1'b1;
        w_push_val  = r_nos;
        w_legal     = w_d_ge2 && !w_is_full;
        w_ovf_cause = w_is_full;
      end
      c_OP_REPLACE: w_legal = w_d_ge1;
      c_OP_ROT:     w_legal = w_d_ge3;
      default:      w_legal = 1'b1;
    endcase
  end

  assign w_accept = i_op_valid && (r_state == ST_READY);
  assign w_do     = w_accept && w_legal;
  assign w_reject = w_accept && !w_legal;

  always_comb begin
    w_state_next = r_state;
    o_op_ready   = 1'b0;
    case (r_state)
      ST_READY: begin
        o_op_ready = 1'b1;
        if (w_do && (i_op == c_OP_ROT)) begin
          w_state_next = ST_ROT_RD;
        end else if (w_do && (i_op == c_OP_DROP) && w_d_ge3) begin
          w_state_next = ST_REFILL;
        end
      end
      ST_REFILL: w_state_next = ST_READY;
      ST_ROT_RD: w_state_next = ST_READY;
      default:   w_state_next = ST_READY;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_READY;
      r_tos     <= '0;
      r_nos     <= '0;
      r_depth   <= '0;
      r_err_ovf <= 1'b0;
      r_err_unf <= 1'b0;
    end else begin
      r_state <= w_state_next;

      // Clear first so that a same-cycle set overrides it.
      if (i_err_clear) begin
        r_err_ovf <= 1'b0;
        r_err_unf <= 1'b0;
      end
      if (w_reject) begin
        if (w_ovf_cause) r_err_ovf <= 1'b1;
        else             r_err_unf <= 1'b1;
      end

      if (w_do) begin
        if (w_push) begin
          r_nos   <= r_tos;
          r_tos   <= w_push_val;
          r_depth <= r_depth + DW'(1);
        end else begin
          case (i_op)
            c_OP_DROP: begin
              r_tos   <= r_nos;
              r_depth <= r_depth - DW'(1);
              // Deeper drops refill nos from RAM in the REFILL cycle.
              if (r_depth == DW'(2)) r_nos <= '0;
              if (r_depth == DW'(1)) begin
                r_tos <= '0;
                r_nos <= '0;
              end
            end
            c_OP_SWAP: begin
              r_tos <= r_nos;
              r_nos <= r_tos;
            end
            c_OP_REPLACE: r_tos <= i_op_wdata;
            default: ;
          endcase
        end
      end

      if (r_state == ST_REFILL) begin
        r_nos <= r_rdata;
      end
      if (r_state == ST_ROT_RD) begin
        r_nos <= r_tos;
        r_tos <= r_rdata;
      end
    end
  end

  // Spill RAM: written on pushes with d>=2 and on the ROT commit (the old
  // nos sinks into the slot the third entry came from).
  assign w_mem_we    = (w_do && w_push && w_d_ge2) || (r_state == ST_ROT_RD);
  assign w_mem_waddr = (r_state == ST_ROT_RD) ? w_addr_m3 : w_addr_m2;
  assign w_mem_re    = w_do && (((i_op == c_OP_DROP) && w_d_ge3) || (i_op == c_OP_ROT));

  always_ff @(posedge i_clk) begin
    if (w_mem_we) r_mem[w_mem_waddr] <= r_nos;
    if (w_mem_re) r_rdata <= r_mem[w_addr_m3];
  end

  assign o_tos           = r_tos;
  assign o_nos           = r_nos;
  assign o_depth         = r_depth;
  assign o_empty         = (r_depth == '0);
  assign o_full          = w_is_full;
  assign o_err_overflow  = r_err_ovf;
  assign o_err_underflow = r_err_unf;

endmodule
`default_nettype wire

// File: tb/tb_forth_stack.sv
`default_nettype none
// ============================================================================
// Module   : tb_forth_stack
// Purpose  : Self-checking bench for forth_stack (DEPTH=4, WIDTH=8).
//            Table of per-cycle vectors with hand-computed expectations, plus
//            an asynchronous reset applied in the middle of a ROT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_forth_stack;

  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, DROP = 3'd2, DUP = 3'd3;
  localparam logic [2:0] SWAP = 3'd4, OVER = 3'd5, REPL = 3'd6, ROT = 3'd7;

  logic       clk;
  logic       rst_n;
  logic       op_valid;
  logic       op_ready;
  logic [2:0] op;
  logic [7:0] op_wdata;
  logic [7:0] tos;
  logic [7:0] nos;
  logic [2:0] depth;
  logic       empty;
  logic       full;
  logic       err_ovf;
  logic       err_unf;
  logic       err_clear;

  forth_stack #(.WIDTH(8), .DEPTH(4)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_op_valid     (op_valid),
    .o_op_ready     (op_ready),
    .i_op           (op),
    .i_op_wdata     (op_wdata),
    .o_tos          (tos),
    .o_nos          (nos),
    .o_depth        (depth),
    .o_empty        (empty),
    .o_full         (full),
    .o_err_overflow (err_ovf),
    .o_err_underflow(err_unf),
    .i_err_clear    (err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [2:0] op;
    logic [7:0] wd;
    logic       clr;
    logic [7:0] tos;
    logic [7:0] nos;
    logic [2:0] d;
    logic       rdy;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic vec_t mk(input logic v, input logic [2:0] o, input logic [7:0] wd,
                              input logic clr, input logic [7:0] t, input logic [7:0] n,
                              input logic [2:0] d, input logic rdy, input logic ovf,
                              input logic unf);
    vec_t r;
    r.v = v; r.op = o; r.wd = wd; r.clr = clr; r.tos = t; r.nos = n;
    r.d = d; r.rdy = rdy; r.ovf = ovf; r.unf = unf;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic check_all(input string tag, input logic [7:0] t, input logic [7:0] n,
                           input logic [2:0] d, input logic rdy, input logic ovf,
                           input logic unf);
    check({tag, " tos"},   32'(tos), 32'(t));
    check({tag, " nos"},   32'(nos), 32'(n));
    check({tag, " depth"}, 32'(depth), 32'(d));
    check({tag, " ready"}, 32'(op_ready), 32'(rdy));
    check({tag, " ovf"},   32'(err_ovf), 32'(ovf));
    check({tag, " unf"},   32'(err_unf), 32'(unf));
    check({tag, " empty"}, 32'(empty), 32'(d == 3'd0));
    check({tag, " full"},  32'(full), 32'(d == 3'd4));
  endtask

  task automatic do_op(input logic [2:0] o, input logic [7:0] wd);
    op_valid = 1'b1; op = o; op_wdata = wd; err_clear = 1'b0;
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  initial begin
    // v, op, wdata, clr | tos, nos, depth, ready, ovf, unf
    vecs.push_back(mk(1, PUSH, 8'h11, 0, 8'h11, 8'h00, 1, 1, 0, 0));
    vecs.push_back(mk(1, PUSH, 8'h22, 0, 8'h22, 8'h11, 2, 1, 0, 0));
    vecs.push_back(mk(1, PUSH, 8'h33, 0, 8'h33, 8'h22, 3, 1, 0, 0));
    vecs.push_back(mk(1, PUSH, 8'h44, 0, 8'h44, 8'h33, 4, 1, 0, 0));
    vecs.push_back(mk(1, PUSH, 8'h55, 0, 8'h44, 8'h33, 4, 1, 1, 0)); // overflow
    vecs.push_back(mk(0, NOP,  8'h00, 1, 8'h44, 8'h33, 4, 1, 0, 0)); // clear
    vecs.push_back(mk(1, DUP,  8'h00, 1, 8'h44, 8'h33, 4, 1, 1, 0)); // set beats clear
    vecs.push_back(mk(0, NOP,  8'h00, 1, 8'h44, 8'h33, 4, 1, 0, 0));
    vecs.push_back(mk(1, DROP, 8'h00, 0, 8'h33, 8'h33, 3, 0, 0, 0)); // refill pending
    vecs.push_back(mk(1, PUSH, 8'h99, 0, 8'h33, 8'h22, 3, 1, 0, 0)); // ignored, not ready
    vecs.push_back(mk(1, DROP, 8'h00, 0, 8'h22, 8'h22, 2, 0, 0, 0));
    vecs.push_back(mk(0, NOP,  8'h00, 0, 8'h22, 8'h11, 2, 1, 0, 0));
    vecs.push_back(mk(1, DROP, 8'h00, 0, 8'h11, 8'h00, 1, 1, 0, 0));
    vecs.push_back(mk(1, DROP, 8'h00, 0, 8'h00, 8'h00, 0, 1, 0, 0));
    vecs.push_back(mk(1, DROP, 8'h00, 0, 8'h00, 8'h00, 0, 1, 0, 1)); // underflow
    vecs.push_back(mk(0, NOP,  8'h00, 1, 8'h00, 8'h00, 0, 1, 0, 0));
    vecs.push_back(mk(1, PUSH, 8'h01, 0, 8'h01, 8'h00, 1, 1, 0, 0));
    vecs.push_back(mk(1, PUSH, 8'h02, 0, 8'h02, 8'h01, 2, 1, 0, 0));
    vecs.push_back(mk(1, PUSH, 8'h03, 0, 8'h03, 8'h02, 3, 1, 0, 0));
    vecs.push_back(mk(1, ROT,  8'h00, 0, 8'h03, 8'h02, 3, 0, 0, 0)); // ROT_RD
    vecs.push_back(mk(1, NOP,  8'h00, 0, 8'h01, 8'h03, 3, 1, 0, 0)); // commit
    vecs.push_back(mk(1, DROP, 8'h00, 0, 8'h03, 8'h03, 2, 0, 0, 0));
    vecs.push_back(mk(0, NOP,  8'h00, 0, 8'h03, 8'h02, 2, 1, 0, 0));
    vecs.push_back(mk(1, DROP, 8'h00, 0, 8'h02, 8'h00, 1, 1, 0, 0));
    vecs.push_back(mk(1, SWAP, 8'h00, 0, 8'h02, 8'h00, 1, 1, 0, 1)); // underflow
    vecs.push_back(mk(0, NOP,  8'h00, 1, 8'h02, 8'h00, 1, 1, 0, 0));
    vecs.push_back(mk(1, DROP, 8'h00, 0, 8'h00, 8'h00, 0, 1, 0, 0));
    vecs.push_back(mk(1, PUSH, 8'h07, 0, 8'h07, 8'h00, 1, 1, 0, 0));
    vecs.push_back(mk(1, PUSH, 8'h09, 0, 8'h09, 8'h07, 2, 1, 0, 0));
    vecs.push_back(mk(1, OVER, 8'h00, 0, 8'h07, 8'h09, 3, 1, 0, 0));
    vecs.push_back(mk(1, DUP,  8'h00, 0, 8'h07, 8'h07, 4, 1, 0, 0));
    vecs.push_back(mk(1, REPL, 8'hAA, 0, 8'hAA, 8'h07, 4, 1, 0, 0));
    vecs.push_back(mk(1, SWAP, 8'h00, 0, 8'h07, 8'hAA, 4, 1, 0, 0));
    vecs.push_back(mk(1, ROT,  8'h00, 0, 8'h07, 8'hAA, 4, 0, 0, 0));
    vecs.push_back(mk(0, NOP,  8'h00, 0, 8'h09, 8'h07, 4, 1, 0, 0));
    vecs.push_back(mk(1, DROP, 8'h00, 0, 8'h07, 8'h07, 3, 0, 0, 0));
    vecs.push_back(mk(0, NOP,  8'h00, 0, 8'h07, 8'hAA, 3, 1, 0, 0));
    vecs.push_back(mk(1, DROP, 8'h00, 0, 8'hAA, 8'hAA, 2, 0, 0, 0));
    vecs.push_back(mk(0, NOP,  8'h00, 0, 8'hAA, 8'h07, 2, 1, 0, 0));
    vecs.push_back(mk(1, OVER, 8'h00, 0, 8'h07, 8'hAA, 3, 1, 0, 0));
    vecs.push_back(mk(1, DROP, 8'h00, 0, 8'hAA, 8'hAA, 2, 0, 0, 0));
    vecs.push_back(mk(0, NOP,  8'h00, 0, 8'hAA, 8'h07, 2, 1, 0, 0));
    vecs.push_back(mk(1, ROT,  8'h00, 0, 8'hAA, 8'h07, 2, 1, 0, 1)); // underflow
    vecs.push_back(mk(1, REPL, 8'h5A, 1, 8'h5A, 8'h07, 2, 1, 0, 0));
    vecs.push_back(mk(1, DROP, 8'h00, 0, 8'h07, 8'h00, 1, 1, 0, 0));
    vecs.push_back(mk(1, OVER, 8'h00, 0, 8'h07, 8'h00, 1, 1, 0, 1)); // underflow
    vecs.push_back(mk(1, DUP,  8'h00, 1, 8'h07, 8'h07, 2, 1, 0, 0));
    vecs.push_back(mk(1, NOP,  8'h00, 0, 8'h07, 8'h07, 2, 1, 0, 0));

    rst_n = 1'b0; op_valid = 1'b0; op = NOP; op_wdata = 8'h00; err_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all("reset", 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      op_valid  = vecs[i].v;
      op        = vecs[i].op;
      op_wdata  = vecs[i].wd;
      err_clear = vecs[i].clr;
      @(posedge clk); #1;
      check_all($sformatf("row%0d", i), vecs[i].tos, vecs[i].nos, vecs[i].d,
                vecs[i].rdy, vecs[i].ovf, vecs[i].unf);
    end
    op_valid = 1'b0; err_clear = 1'b0;

    // Asynchronous reset landing in the ROT_RD cycle.
    do_op(DROP, 8'h00);
    do_op(DROP, 8'h00);
    do_op(PUSH, 8'h01);
    do_op(PUSH, 8'h02);
    do_op(PUSH, 8'h03);
    check_all("pre-rot", 8'h03, 8'h02, 3'd3, 1'b1, 1'b0, 1'b0);
    do_op(ROT, 8'h00);
    check("rot busy ready", 32'(op_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_all("async rst", 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op(PUSH, 8'h05);
    check_all("post-rst push", 8'h05, 8'h00, 3'd1, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/forth_stack.md
# forth_stack

Parametrised data/return stack engine for the forth core, the successor to the plain push/pop stack. Top two entries live in registers (`tos`, `nos`); deeper entries spill to a synchronous-read RAM. Forth stack words (DUP, SWAP, OVER, ROT, …) execute as single accepted operations under a valid/ready handshake. Depth is reported, and overflow/underflow are detected with sticky error flags.

## Interface
- `WIDTH`, 8: data word width in bits.
- `DEPTH`, 16: maximum entries. Power of two, ≥4. Spill RAM holds `DEPTH-2` words.
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `op_valid` in 1: operation request.
- `op_ready` out 1: engine can accept an operation this cycle.
- `op` in 3: opcode. 0 NOP, 1 PUSH, 2 DROP, 3 DUP, 4 SWAP, 5 OVER, 6 REPLACE, 7 ROT.
- `op_wdata` in WIDTH: operand for PUSH/REPLACE.
- `tos` out WIDTH: top of stack, registered.
- `nos` out WIDTH: next of stack, registered.
- `depth` out $clog2(DEPTH)+1: current entry count d.
- `empty` / `full` out 1 each: d==0 / d==DEPTH (combinational from `depth`).
- `err_overflow` / `err_underflow` out 1 each: sticky error flags.
- `err_clear` in 1: clears both sticky flags.

## Operation
- Storage mapping: `tos` = entry d-1, `nos` = entry d-2, RAM address i = entry i for i ≤ d-3.
- Accept = `op_valid && op_ready`. Nothing changes without accept.
- Requirements per op (failing op is rejected):
  - PUSH/DUP need d≥1 (DUP only), d<DEPTH.
  - OVER needs 2≤d<DEPTH.
  - DROP needs d≥1.
  - SWAP needs d≥2.
  - REPLACE needs d≥1.
  - ROT needs d≥3.
  - NOP always legal, no effect.
- Rejected op: state unchanged, single cycle. Sets `err_overflow` if d==DEPTH was the cause (push-type ops), otherwise `err_underflow`. Flag set has priority over `err_clear` in the same cycle.
- PUSH x / DUP / OVER push value v (x / `tos` / `nos`):
  - RAM[d-2] ← `nos` if d≥2.
  - `nos` ← `tos`, `tos` ← v, d+1.
- DROP:
  - `tos` ← `nos`, d-1.
  - If new d≥2: RAM read at d-3, `nos` ← read data in REFILL.
  - If new d==1: `nos` ← 0.
  - If new d==0: `tos` ← 0.
- SWAP: exchange `tos`/`nos`.
- REPLACE: `tos` ← `op_wdata`.
- ROT (a b c → b c a, c = tos):
  - RAM read at d-3 during ROT_RD.
  - Commit: RAM[d-3] ← `nos`, `nos` ← `tos`, `tos` ← a.
- States:
  - READY: `op_ready`=1. Legal DROP with d≥3 → REFILL. Legal ROT → ROT_RD. Else stay.
  - REFILL: `op_ready`=0, loads `nos`, → READY.
  - ROT_RD: `op_ready`=0, performs ROT commit, → READY.
- Reset (any time, including mid-REFILL/ROT_RD): state READY, d=0, `tos`=`nos`=0, flags 0, `op_ready`=1. RAM contents not cleared.

## Timing
- Single-cycle ops (NOP, PUSH, DUP, OVER, SWAP, REPLACE, DROP with d≤2, any rejected op): outputs update at the accepting edge; next op accepted the following cycle.
- DROP with d≥3: `tos`/`depth` update at the accepting edge; `nos` updates one edge later. `op_ready` low for exactly one cycle.
- ROT: all outputs update at the second edge after accept. `op_ready` low for exactly one cycle.
- Sustained throughput 1 op/cycle except DROP(d≥3) and ROT (2 cycles each).
- `empty`, `full` track `depth` with no extra latency.
- `op_wdata` sampled only at the accepting edge.

## Test plan
- Reset then PUSH 0x11, 0x22, 0x33 → `tos`=0x33, `nos`=0x22, `depth`=3, `op_ready` high every cycle.
- With DEPTH=4: PUSH 1,2,3,4 then PUSH 5 → `full`=1, `err_overflow`=1, `tos`=4, `depth`=4. `err_clear` pulse → flag 0.
- Stack 1,2,3,4 (tos=4): DROP → `tos`=3 immediately, `op_ready`=0 one cycle, then `nos`=2. DROP ×3 → `empty`=1, `tos`=`nos`=0. Further DROP → `err_underflow`=1, `depth`=0.
- Stack 1,2,3: ROT → after 2 edges `tos`=1, `nos`=3. DROP, DROP → `tos`=2. SWAP on d=1 → `err_underflow`=1, `tos` unchanged.
- Stack 7,9: OVER → 7,9,7. DUP → `depth`=4. REPLACE 0xAA → `tos`=0xAA, `nos`=7.
- Assert `rst` low during ROT_RD (stack 1,2,3) → `depth`=0, `op_ready`=1 immediately (async); after release PUSH 5 → `tos`=5, `depth`=1.
